panel_command_sequencer: RTL and testbench
==========================================

// Module: panel_command_sequencer
// PURPOSE
// Downstream of the front-panel renderer: consumes its 25 x 2-bit switch states and turns them into
// machine commands. Commands are examine, deposit, run/stop, single-step and reset, issued to the
// CPU/memory bus via valid/ready. Tracks the panel address register and run mode; exports aux switches as levels.
// PARAMETERS
// DEBOUNCE_CYCLES  1024  cycles a toggle value must hold unchanged before it is accepted (>=1)
// ADDR_WIDTH       16    panel address width; switch idx 0 = A15 ... idx 15 = A0
// DATA_WIDTH       8     deposit data width; taken from A7..A0 (idx 8..15)
// PORTS
// clk              in   1   system clock
// reset            in   1   async reset, active-high
// switches_status  in   2x25 per-switch state; single-throw 0=down,1=up; toggles 0=mid,2=up,1=down
// cmd_valid        out  1   command pending
// cmd_ready        in   1   consumer accepts command when cmd_valid&cmd_ready
// cmd_op           out  3   panel_op_t opcode
// cmd_addr         out  ADDR_WIDTH  target address
// cmd_data         out  DATA_WIDTH  deposit data (don't-care for other ops)
// run_mode         out  1   1 = CPU running
// panel_addr       out  ADDR_WIDTH  current examine/deposit address (for address LEDs)
// aux_sw           out  2   levels of idx 23 (bit0) and 24 (bit1)
// BEHAVIOUR
// Clocking and reset: one clock domain. Async reset clears cmd_valid, cmd_op, cmd_addr, cmd_data, run_mode,
//   panel_addr, aux_sw, all debounce counters; FSM->IDLE. Reset mid-handshake drops the command.
// Toggle map (idx): 18 up=STOP dn=RUN; 19 up=STEP dn=ignored(slow); 20 up=EXAMINE dn=EXAMINE_NEXT;
//   21 up=DEPOSIT dn=DEPOSIT_NEXT; 22 up=RESET dn=CLR. idx 16,17 ignored.
// Debounce: every input bit sampled into a register (1 cycle). Each toggle has a counter that reloads on
//   any change. Debounced value updates once DEBOUNCE_CYCLES identical samples are seen. Address/aux bits
//   are not debounced; aux_sw is a 1-cycle registered copy.
// Event: debounced toggle goes mid->up or mid->down. Up<->down without passing mid is not an event.
// Simultaneous events in the same cycle: lowest idx wins; the others are discarded.
// FSM IDLE -> ISSUE -> HOLD -> IDLE:
//   IDLE: on event, act per table below. Events that issue a command go to ISSUE with cmd_valid=1
//     the following cycle. Other events go to HOLD.
//   ISSUE: cmd_* stable while cmd_valid=1 until cmd_ready. Handshake completes same cycle -> HOLD,
//     cmd_valid=0 next cycle. Latency from debounced event to cmd_valid: 1 cycle.
//   HOLD: wait until the triggering toggle is debounced mid, then IDLE. One command per lever throw.
// Actions (A = address switches, T = current panel_addr):
//   STOP: run_mode<=0, no cmd.  RUN: run_mode<=1, no cmd.
//   STEP (only if run_mode=0): op STEP, addr T.
//   EXAMINE (only if stopped): panel_addr<=A; op EXAMINE, addr A.
//   EXAMINE_NEXT (stopped): panel_addr<=T+1 mod 2^ADDR_WIDTH (FFFF->0000); op EXAMINE_NEXT, addr T+1.
//   DEPOSIT (stopped): op DEPOSIT, addr T, data A[7:0]; panel_addr unchanged.
//   DEPOSIT_NEXT (stopped): panel_addr<=T+1 (wrap); op DEPOSIT_NEXT, addr T+1, data A[7:0].
//   RESET: run_mode<=0, panel_addr<=0, op RESET (allowed while running). CLR: op CLR.
//   Examine/deposit/step while running: ignored, but FSM still enters HOLD.
// Timing of state updates: panel_addr and run_mode update in the cycle the event is taken in IDLE.
//   Events arriving during ISSUE/HOLD are discarded, not queued.
// STRUCTURE
// panel_pkg: typedef enum logic[2:0] panel_op_t {EXAMINE=0,EXAMINE_NEXT=1,DEPOSIT=2,DEPOSIT_NEXT=3,
//   STEP=4,RESET=5,CLR=6}; switch index constants (SW_ADDR_MSB=0, SW_RUN_STOP=18, SW_STEP=19,
//   SW_EXAMINE=20, SW_DEPOSIT=21, SW_RESET=22, SW_AUX1=23, SW_AUX2=24); toggle codes TG_MID=0,TG_DN=1,TG_UP=2.
// Sub-module toggle_debounce (one per toggle, x5): 2-bit sample, counter, debounced value, event pulses up/down.
// TESTING
// 1. DEBOUNCE_CYCLES=4; idx20=2 held 3 cycles then 0 -> no cmd_valid; held 4 -> one EXAMINE.
// 2. Stopped, A=0x1234, idx20 up->mid: EXAMINE addr 0x1234, panel_addr=0x1234; idx20 down twice:
//    EXAMINE_NEXT 0x1235 then 0x1236.
// 3. panel_addr=0xFFFF, A[7:0]=0xA5, idx21 down: DEPOSIT_NEXT addr 0x0000 data 0xA5. cmd_ready low 10 cycles:
//    cmd_* held stable, exactly one handshake.
// 4. idx18 down -> run_mode=1; idx19 up and idx20 up -> no cmd; idx22 up -> RESET, run_mode=0, panel_addr=0.
// 5. idx20 and idx21 both go up in the same cycle -> only EXAMINE issued; idx21 event is lost.
// 6. reset asserted while cmd_valid=1 -> all outputs 0 asynchronously; after release, levers mid, no command.

Source files
------------

// File: rtl/panel_pkg.sv
// Shared opcodes, switch map and toggle codes for the panel command sequencer.
package panel_pkg;

    typedef enum logic [2:0] {
        EXAMINE      = 3'd0,
        EXAMINE_NEXT = 3'd1,
        DEPOSIT      = 3'd2,
        DEPOSIT_NEXT = 3'd3,
        STEP         = 3'd4,
        RESET        = 3'd5,
        CLR          = 3'd6
    } panel_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } seq_state_t;

    localparam int NUM_SW      = 25;
    localparam int NUM_TOG     = 5;
    localparam int SW_ADDR_MSB = 0;
    localparam int SW_RUN_STOP = 18;
    localparam int SW_STEP     = 19;
    localparam int SW_EXAMINE  = 20;
    localparam int SW_DEPOSIT  = 21;
    localparam int SW_RESET    = 22;
    localparam int SW_AUX1     = 23;
    localparam int SW_AUX2     = 24;

    // Toggle position within the debounced bank (bank starts at SW_RUN_STOP).
    localparam logic [2:0] TOG_RUN_STOP = 3'(SW_RUN_STOP - SW_RUN_STOP);
    localparam logic [2:0] TOG_STEP     = 3'(SW_STEP - SW_RUN_STOP);
    localparam logic [2:0] TOG_EXAMINE  = 3'(SW_EXAMINE - SW_RUN_STOP);
    localparam logic [2:0] TOG_DEPOSIT  = 3'(SW_DEPOSIT - SW_RUN_STOP);
    localparam logic [2:0] TOG_RESET    = 3'(SW_RESET - SW_RUN_STOP);

    localparam logic [1:0] TG_MID = 2'd0;
    localparam logic [1:0] TG_DN  = 2'd1;
    localparam logic [1:0] TG_UP  = 2'd2;

endpackage

// File: rtl/toggle_debounce.sv
// One three-position toggle: registered sample, run-length counter, debounced
// level and single-cycle mid->up / mid->down event pulses.
module toggle_debounce
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sw_raw,
    output logic [1:0] deb_val,
    output logic       ev_up,
    output logic       ev_dn
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [1:0]    sample_q, sample_d;
    logic [1:0]    last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    deb_q, deb_d;
    logic          settled;

    // cnt counts consecutive identical samples held in last; a change restarts it at one.
    always_comb begin
        sample_d = sw_raw;
        last_d   = sample_q;
        cnt_d    = cnt_q;
        if (sample_q != last_q)
            cnt_d = CW'(1);
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + CW'(1);
        settled = (cnt_q == CNT_MAX);
        deb_d   = settled ? last_q : deb_q;
        // Only transitions leaving mid are events; up<->down directly is not.
        ev_up   = settled && (deb_q == TG_MID) && (last_q == TG_UP);
        ev_dn   = settled && (deb_q == TG_MID) && (last_q == TG_DN);
    end

    // Sample, counter and debounced level registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_q <= TG_MID;
            last_q   <= TG_MID;
            cnt_q    <= '0;
            deb_q    <= TG_MID;
        end else begin
            sample_q <= sample_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            deb_q    <= deb_d;
        end
    end

    assign deb_val = deb_q;

endmodule

// File: rtl/panel_command_sequencer.sv
// Turns front-panel switch states into examine/deposit/step/reset/clear bus
// commands, tracks run mode and the panel address register.
module panel_command_sequencer
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_SW-1:0][1:0]       switches_status,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output panel_op_t                    cmd_op,
    output logic [ADDR_WIDTH-1:0]        cmd_addr,
    output logic [DATA_WIDTH-1:0]        cmd_data,
    output logic                         run_mode,
    output logic [ADDR_WIDTH-1:0]        panel_addr,
    output logic [1:0]                   aux_sw
);

    logic [ADDR_WIDTH-1:0] addr_sw_q, addr_sw_d;
    logic [1:0]            aux_q, aux_d;
    logic                  unused_sw_bits;

    logic [NUM_TOG-1:0][1:0] tog_deb;
    logic [NUM_TOG-1:0]      tog_up;
    logic [NUM_TOG-1:0]      tog_dn;

    logic       ev_hit;
    logic [2:0] ev_idx;
    logic       ev_is_up;
    logic [1:0] hold_deb;

    seq_state_t            state_q;
    logic [2:0]            hold_idx_q;
    logic                  cmd_valid_q;
    panel_op_t             cmd_op_q;
    logic [ADDR_WIDTH-1:0] cmd_addr_q;
    logic [DATA_WIDTH-1:0] cmd_data_q;
    logic                  run_mode_q;
    logic [ADDR_WIDTH-1:0] panel_addr_q;
    logic [ADDR_WIDTH-1:0] addr_inc;

    // Address and aux switches are single-throw levels: bit0 carries up/down.
    always_comb begin
        addr_sw_d = '0;
        for (int i = 0; i < ADDR_WIDTH; i++)
            addr_sw_d[ADDR_WIDTH-1-i] = switches_status[SW_ADDR_MSB+i][0];
        aux_d = {switches_status[SW_AUX2][0], switches_status[SW_AUX1][0]};
        unused_sw_bits = ^{switches_status[16], switches_status[17],
                           switches_status[SW_AUX1][1], switches_status[SW_AUX2][1]};
        for (int i = 0; i < ADDR_WIDTH; i++)
            unused_sw_bits = unused_sw_bits ^ switches_status[SW_ADDR_MSB+i][1];
    end

    // Undebounced level switches: one register stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_sw_q <= '0;
            aux_q     <= '0;
        end else begin
            addr_sw_q <= addr_sw_d;
            aux_q     <= aux_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_TOG; g++) begin : g_tog
            toggle_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_tog (
                .clk    (clk),
                .reset  (reset),
                .sw_raw (switches_status[SW_RUN_STOP+g]),
                .deb_val(tog_deb[g]),
                .ev_up  (tog_up[g]),
                .ev_dn  (tog_dn[g])
            );
        end
    endgenerate

    // Same-cycle events: lowest switch index wins, others are dropped.
    always_comb begin
        ev_hit   = 1'b0;
        ev_idx   = '0;
        ev_is_up = 1'b0;
        for (int i = NUM_TOG - 1; i >= 0; i--) begin
            if (tog_up[i] || tog_dn[i]) begin
                ev_hit   = 1'b1;
                ev_idx   = 3'(i);
                ev_is_up = tog_up[i];
            end
        end
        hold_deb = TG_MID;
        for (int i = 0; i < NUM_TOG; i++)
            if (hold_idx_q == 3'(i)) hold_deb = tog_deb[i];
        addr_inc = panel_addr_q + ADDR_WIDTH'(1);
    end

    // Sequencer FSM: take one event in IDLE, present command, then wait for the lever to return to mid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hold_idx_q   <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_op_q     <= EXAMINE;
            cmd_addr_q   <= '0;
            cmd_data_q   <= '0;
            run_mode_q   <= 1'b0;
            panel_addr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ev_hit) begin
                        hold_idx_q <= ev_idx;
                        state_q    <= ST_HOLD;
                        case (ev_idx)
                            TOG_RUN_STOP: run_mode_q <= !ev_is_up;
                            TOG_STEP: begin
                                if (ev_is_up && !run_mode_q) begin
                                    cmd_valid_q <= 1'b1;
                                    cmd_op_q    <= STEP;
                                    cmd_addr_q  <= panel_addr_q;
                                    state_q     <= ST_ISSUE;
                                end
                            end
                            TOG_EXAMINE: begin
                                if (!run_mode_q) begin
                                    cmd_valid_q <= 1'b1;
                                    state_q     <= ST_ISSUE;
                                    if (ev_is_up) begin
                                        panel_addr_q <= addr_sw_q;
                                        cmd_op_q     <= EXAMINE;
                                        cmd_addr_q   <= addr_sw_q;
                                    end else begin
                                        panel_addr_q <= addr_inc;
                                        cmd_op_q     <= EXAMINE_NEXT;
                                        cmd_addr_q   <= addr_inc;
                                    end
                                end
                            end
                            TOG_DEPOSIT: begin
                                if (!run_mode_q) begin
                                    cmd_valid_q <= 1'b1;
                                    cmd_data_q  <= addr_sw_q[DATA_WIDTH-1:0];
                                    state_q     <= ST_ISSUE;
                                    if (ev_is_up) begin
                                        cmd_op_q   <= DEPOSIT;
                                        cmd_addr_q <= panel_addr_q;
                                    end else begin
                                        panel_addr_q <= addr_inc;
                                        cmd_op_q     <= DEPOSIT_NEXT;
                                        cmd_addr_q   <= addr_inc;
                                    end
                                end
                            end
                            TOG_RESET: begin
                                cmd_valid_q <= 1'b1;
                                state_q     <= ST_ISSUE;
                                if (ev_is_up) begin
                                    run_mode_q   <= 1'b0;
                                    panel_addr_q <= '0;
                                    cmd_op_q     <= RESET;
                                    cmd_addr_q   <= '0;
                                end else begin
                                    cmd_op_q   <= CLR;
                                    cmd_addr_q <= panel_addr_q;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_deb == TG_MID) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_op     = cmd_op_q;
    assign cmd_addr   = cmd_addr_q;
    assign cmd_data   = cmd_data_q;
    assign run_mode   = run_mode_q;
    assign panel_addr = panel_addr_q;
    assign aux_sw     = aux_q;

endmodule

// File: tb/tb_panel_command_sequencer.sv
// Scoreboard bench: lever throws update a behavioural panel model and queue
// the expected command; a monitor checks every presented command.
module tb_panel_command_sequencer;
    import panel_pkg::*;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 8;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [24:0][1:0]      sw = '0;
    logic                  cmd_valid;
    logic                  cmd_ready;
    panel_op_t             cmd_op;
    logic [AW-1:0]         cmd_addr;
    logic [DW-1:0]         cmd_data;
    logic                  run_mode;
    logic [AW-1:0]         panel_addr;
    logic [1:0]            aux_sw;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] addr;
        logic [7:0]  data;
        bit          chk_addr;
        bit          chk_data;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    bit          stall = 1'b1;
    bit          m_run = 1'b0;
    logic [15:0] m_pa = '0;

    panel_command_sequencer #(
        .DEBOUNCE_CYCLES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .reset(reset), .switches_status(sw),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .run_mode(run_mode),
        .panel_addr(panel_addr), .aux_sw(aux_sw)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every cycle a command is presented it must match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && cmd_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_cmd_valid", 32'(cmd_valid), 32'd0);
                end else begin
                    chk("cmd_op", 32'(cmd_op), 32'(q[0].op));
                    if (q[0].chk_addr) chk("cmd_addr", 32'(cmd_addr), 32'(q[0].addr));
                    if (q[0].chk_data) chk("cmd_data", 32'(cmd_data), 32'(q[0].data));
                    if (cmd_ready) void'(q.pop_front());
                end
            end
        end
    end

    // Consumer: mostly ready, random back-pressure, forced low while stalled.
    initial begin
        cmd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cmd_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Panel model: what a single lever throw does to run mode, address and the bus.
    task automatic model(int idx, bit up, logic [15:0] a);
        exp_t e;
        e.op = '0; e.addr = '0; e.data = a[7:0]; e.chk_addr = 1'b1; e.chk_data = 1'b0;
        case (idx)
            18: m_run = !up;
            19: if (up && !m_run) begin e.op = STEP; e.addr = m_pa; q.push_back(e); end
            20: if (!m_run) begin
                    m_pa = up ? a : m_pa + 16'd1;
                    e.op = up ? EXAMINE : EXAMINE_NEXT;
                    e.addr = m_pa; q.push_back(e);
                end
            21: if (!m_run) begin
                    if (!up) m_pa = m_pa + 16'd1;
                    e.op = up ? DEPOSIT : DEPOSIT_NEXT;
                    e.addr = m_pa; e.chk_data = 1'b1; q.push_back(e);
                end
            22: begin
                    if (up) begin m_run = 1'b0; m_pa = '0; e.op = RESET; end
                    else e.op = CLR;
                    e.chk_addr = 1'b0; q.push_back(e);
                end
            default: ;
        endcase
    endtask

    task automatic set_addr(logic [15:0] a);
        for (int i = 0; i < 16; i++) sw[i] = {1'b0, a[15-i]};
    endtask

    task automatic go(int idx, bit up, logic [15:0] a);
        @(posedge clk); #1;
        set_addr(a);
        sw[idx] = up ? 2'd2 : 2'd1;
        model(idx, up, a);
    endtask

    task automatic drain_settle();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        chk("drain_queue", 32'(q.size()), 32'd0);
        repeat (N + 6) @(posedge clk);
    endtask

    task automatic release_all();
        @(posedge clk); #1;
        for (int i = 18; i <= 22; i++) sw[i] = 2'd0;
        drain_settle();
    endtask

    task automatic check_state(string tag);
        @(negedge clk);
        chk({tag, "_run_mode"}, 32'(run_mode), 32'(m_run));
        chk({tag, "_panel_addr"}, 32'(panel_addr), 32'(m_pa));
        chk({tag, "_aux_sw"}, 32'(aux_sw), 32'({sw[24][0], sw[23][0]}));
    endtask

    task automatic throw(int idx, bit up, logic [15:0] a);
        go(idx, up, a);
        repeat (N + 6) @(posedge clk);
        check_state("throw");
        release_all();
    endtask

    task automatic wait_valid(string tag);
        for (int i = 0; i < 100 && !cmd_valid; i++) @(negedge clk);
        chk(tag, 32'(cmd_valid), 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_run_mode", 32'(run_mode), 32'd0);
        chk("rst_panel_addr", 32'(panel_addr), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        stall = 1'b0;
        repeat (4) @(posedge clk);

        // Debounce threshold: 3 samples rejected, 4 accepted.
        @(posedge clk); #1; sw[20] = 2'd2;
        repeat (3) @(posedge clk); #1; sw[20] = 2'd0;
        drain_settle();
        check_state("glitch");
        go(20, 1'b1, 16'h0042);
        repeat (3) @(posedge clk);
        release_all();
        check_state("hold4");

        // Examine then examine-next twice.
        throw(20, 1'b1, 16'h1234);
        throw(20, 1'b0, 16'h0000);
        throw(20, 1'b0, 16'h0000);

        // Deposit-next across the address wrap under 10 cycles of back-pressure.
        throw(20, 1'b1, 16'hFFFF);
        stall = 1'b1;
        go(21, 1'b0, 16'h12A5);
        wait_valid("t3_valid_seen");
        repeat (10) @(negedge clk);
        stall = 1'b0;
        repeat (N + 6) @(posedge clk);
        check_state("t3");
        release_all();

        // Running: step/examine/deposit ignored, reset stops and clears address.
        throw(18, 1'b0, 16'h0000);
        throw(19, 1'b1, 16'h0000);
        throw(20, 1'b1, 16'h4321);
        throw(21, 1'b0, 16'h0077);
        throw(22, 1'b1, 16'h0000);

        // Simultaneous examine and deposit: only examine survives.
        @(posedge clk); #1;
        set_addr(16'h0BEE);
        sw[20] = 2'd2; sw[21] = 2'd2;
        model(20, 1'b1, 16'h0BEE);
        repeat (N + 6) @(posedge clk);
        check_state("t5");
        release_all();

        // Random lever traffic.
        for (int k = 0; k < 30; k++) begin
            sw[23] = 2'($urandom_range(0, 1));
            sw[24] = 2'($urandom_range(0, 1));
            throw(18 + $urandom_range(0, 4), 1'($urandom_range(0, 1)), 16'($urandom));
        end

        // Reset while a command is held by back-pressure.
        throw(18, 1'b1, 16'h0000);
        sw[23] = 2'd1; sw[24] = 2'd1;
        stall = 1'b1;
        go(20, 1'b1, 16'h5555);
        wait_valid("t6_valid_seen");
        chk("t6_aux_before", 32'(aux_sw), 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("t6_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("t6_cmd_op", 32'(cmd_op), 32'd0);
        chk("t6_cmd_addr", 32'(cmd_addr), 32'd0);
        chk("t6_cmd_data", 32'(cmd_data), 32'd0);
        chk("t6_run_mode", 32'(run_mode), 32'd0);
        chk("t6_panel_addr", 32'(panel_addr), 32'd0);
        chk("t6_aux_sw", 32'(aux_sw), 32'd0);
        q.delete();
        m_run = 1'b0;
        m_pa  = '0;
        for (int i = 18; i <= 24; i++) sw[i] = 2'd0;
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;
        stall = 1'b0;
        repeat (N + 10) @(posedge clk);
        check_state("t6_after");
        chk("t6_no_cmd", 32'(cmd_valid), 32'd0);

        chk("final_queue_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
